// File: rtl/ahb_sram_if_if.sv
// Signal bundle for ahb_sram_if: AHB-Lite slave port, BIST handoff flag and
// single-port SRAM strobes. The slave modport is the bridge's view.
interface ahb_sram_if_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  hsel;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [31:0]           hwdata;
  logic                  hready;
  logic                  hready_out;
  logic [1:0]            hresp;
  logic [31:0]           hrdata;
  logic                  bist_te;
  logic [31:0]           sram_rdata;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [3:0]            sram_wen;
  logic                  sram_cen;
  logic                  sram_oen;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready, bist_te, sram_rdata,
    output hready_out, hresp, hrdata, sram_addr, sram_wdata, sram_wen, sram_cen, sram_oen
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready, bist_te, sram_rdata,
    input  hready_out, hresp, hrdata, sram_addr, sram_wdata, sram_wen, sram_cen, sram_oen
  );
endinterface

// File: rtl/ahb_sram_if.sv
// AHB-Lite to single-port SRAM bridge: zero-wait reads, posted writes, one stall on read-after-write.
// Define AHB_SRAM_ERR_RESP_EN to answer illegal size/alignment with a two-cycle ERROR response.
module ahb_sram_if #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic          hclk,
  input  logic          hresetn,
  ahb_sram_if_if.slave  bus
);

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [3:0]            r_lanes;
  logic [3:0]            w_lanes_nxt;
  logic [ADDR_WIDTH-1:0] w_haddr_word;
  logic                  w_open;
  logic                  w_acc;
  logic                  w_bad;
  logic                  w_rd_now;
  logic [32-ADDR_WIDTH-2:0] w_unused_bits;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'd0:    lane_mask = 4'b0001 << lsb;
      3'd1:    lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic bad_access(input logic [2:0] size, input logic [1:0] lsb);
    bad_access = (size > 3'd2) || ((size == 3'd1) && lsb[0]) ||
                 ((size == 3'd2) && (lsb != 2'b00));
  endfunction

  assign w_haddr_word  = bus.haddr[ADDR_WIDTH+1:2];
  assign w_unused_bits = {bus.haddr[31:ADDR_WIDTH+2], bus.htrans[0]};

  // An address phase can only complete in states that drive hready_out high.
  assign w_open = (r_state == S_WR) || (r_state == S_RD) || (r_state == S_ERR2) ||
                  ((r_state == S_IDLE) && !bus.bist_te);
  assign w_acc  = hresetn && w_open && bus.hsel && bus.htrans[1] && bus.hready;
  assign w_bad  = ERR_EN && bad_access(bus.hsize, bus.haddr[1:0]);
  // Reads go straight to the SRAM unless the port is busy with a write data phase.
  assign w_rd_now = w_acc && !w_bad && !bus.hwrite && (r_state != S_WR);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_lanes <= '0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_nxt;
      r_lanes <= w_lanes_nxt;
    end
  end

  always_comb begin
    w_next      = S_IDLE;
    w_addr_nxt  = r_addr;
    w_lanes_nxt = r_lanes;
    case (r_state)
      S_RD_WAIT: w_next = S_RD;
      S_ERR1:    w_next = S_ERR2;
      default: begin
        if (w_acc) begin
          if (w_bad) begin
            w_next = S_ERR1;
          end else if (bus.hwrite) begin
            w_next      = S_WR;
            w_addr_nxt  = w_haddr_word;
            w_lanes_nxt = lane_mask(bus.hsize, bus.haddr[1:0]);
          end else if (r_state == S_WR) begin
            w_next     = S_RD_WAIT;
            w_addr_nxt = w_haddr_word;
          end else begin
            w_next = S_RD;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.sram_cen   = 1'b1;
    bus.sram_oen   = 1'b1;
    bus.sram_wen   = 4'hF;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.hready_out = 1'b1;
    bus.hresp      = 2'b00;
    bus.hrdata     = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.bist_te && hresetn) bus.hready_out = 1'b0;
      end
      S_WR: begin
        bus.sram_cen   = 1'b0;
        bus.sram_wen   = ~r_lanes;
        bus.sram_addr  = r_addr;
        bus.sram_wdata = bus.hwdata;
      end
      S_RD: begin
        bus.hrdata = bus.sram_rdata;
      end
      S_RD_WAIT: begin
        bus.hready_out = 1'b0;
        bus.sram_cen   = 1'b0;
        bus.sram_oen   = 1'b0;
        bus.sram_addr  = r_addr;
      end
      S_ERR1: begin
        bus.hready_out = 1'b0;
        bus.hresp      = {1'b0, ERR_EN};
      end
      S_ERR2: begin
        bus.hresp = {1'b0, ERR_EN};
      end
      default: begin
        bus.hready_out = 1'b1;
      end
    endcase
    if (w_rd_now) begin
      bus.sram_cen  = 1'b0;
      bus.sram_oen  = 1'b0;
      bus.sram_wen  = 4'hF;
      bus.sram_addr = w_haddr_word;
    end
  end

endmodule

// File: tb/tb_ahb_sram_if.sv
// Bench for ahb_sram_if: pipelined AHB master, SRAM model and a word-array memory
// reference; directed corner cases followed by randomized transfer streams.
module tb_ahb_sram_if;
  localparam int AW = 13;
`ifdef AHB_SRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit          idle;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } txn_t;

  logic hclk = 1'b0;
  logic hresetn;
  logic mem_init;

  ahb_sram_if_if #(.ADDR_WIDTH(AW)) bus ();
  ahb_sram_if #(.ADDR_WIDTH(AW)) dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));

  always #5 hclk = ~hclk;
  assign bus.hready = bus.hready_out;

  logic [31:0]   sram_mem [1<<AW];
  logic [31:0]   ref_mem  [1<<AW];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_strobe = 0;
  int            n_rst_strobe = 0;
  logic [3:0]    last_wen = 4'hF;
  logic [AW-1:0] last_waddr = '0;
  logic [AW-1:0] last_raddr = '0;
  txn_t          q[$];

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // SRAM macro model: registered read data, per-lane active-low write enables.
  always @(posedge hclk) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) sram_mem[i] <= init_word(i);
    end else if (!bus.sram_cen) begin
      if (!bus.sram_oen) bus.sram_rdata <= sram_mem[bus.sram_addr];
      for (int k = 0; k < 4; k++)
        if (!bus.sram_wen[k]) sram_mem[bus.sram_addr][k*8 +: 8] <= bus.sram_wdata[k*8 +: 8];
    end
  end

  always @(negedge hclk) begin
    if (!hresetn && !bus.sram_cen) n_rst_strobe <= n_rst_strobe + 1;
    if (hresetn && !bus.sram_cen && bus.sram_wen != 4'hF) begin
      n_strobe   <= n_strobe + 1;
      last_wen   <= bus.sram_wen;
      last_waddr <= bus.sram_addr;
    end
    if (hresetn && !bus.sram_cen && !bus.sram_oen) last_raddr <= bus.sram_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(bit idle, bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] data);
    txn_t t;
    t.idle = idle; t.wr = wr; t.addr = addr; t.size = size; t.data = data;
    return t;
  endfunction

  function automatic bit is_bad(txn_t t);
    return ERR_EN && ((t.size > 3'd2) || (t.size == 3'd1 && t.addr % 2 != 0) ||
                      (t.size == 3'd2 && t.addr % 4 != 0));
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic model_write(txn_t t);
    int w;
    bit hit;
    w = word_of(t.addr);
    for (int k = 0; k < 4; k++) begin
      if (t.size == 3'd0)      hit = (k == int'(t.addr % 4));
      else if (t.size == 3'd1) hit = (k / 2 == int'((t.addr / 2) % 2));
      else                     hit = 1'b1;
      if (hit) ref_mem[w][k*8 +: 8] = t.data[k*8 +: 8];
    end
  endtask

  task automatic drive_addr(bit act, txn_t t);
    bus.hsel   = act;
    bus.htrans = act ? 2'b10 : 2'b00;
    bus.haddr  = act ? t.addr : 32'h0;
    bus.hwrite = act & t.wr;
    bus.hsize  = act ? t.size : 3'd0;
  endtask

  task automatic complete(txn_t t, bit col, int waits);
    bit bad;
    bad = is_bad(t);
    chk($sformatf("resp@%08h", t.addr), 32'(bus.hresp), bad ? 32'd1 : 32'd0);
    chk($sformatf("waits@%08h", t.addr), 32'(waits), (bad || col) ? 32'd1 : 32'd0);
    if (!bad && !t.wr) chk($sformatf("rdata@%08h", t.addr), bus.hrdata, ref_mem[word_of(t.addr)]);
    if (!bad && t.wr) model_write(t);
  endtask

  // Plays the queue as a pipelined AHB master; called right after a rising edge.
  task automatic run_seq();
    txn_t dp, nxt;
    bit   dp_vld, dp_col;
    int   i, waits;
    dp = mk(1'b1, 1'b0, 32'h0, 3'd0, 32'h0);
    dp_vld = 1'b0; dp_col = 1'b0; i = 0; waits = 0;
    while (i < q.size() || dp_vld) begin
      nxt = (i < q.size()) ? q[i] : mk(1'b1, 1'b0, 32'h0, 3'd0, 32'h0);
      drive_addr(!nxt.idle, nxt);
      bus.hwdata = (dp_vld && dp.wr) ? dp.data : 32'h0;
      @(negedge hclk);
      if (!bus.hready_out) begin
        waits++;
        if (waits > 8) begin
          chk("stall", 32'(waits), 32'd1);
          dp_vld = 1'b0;
          i = q.size();
        end
        @(posedge hclk); #1;
      end else begin
        if (dp_vld) complete(dp, dp_col, waits);
        @(posedge hclk); #1;
        dp_col = dp_vld && dp.wr && !is_bad(dp) && !nxt.idle && !nxt.wr && !is_bad(nxt);
        dp     = nxt;
        dp_vld = !nxt.idle;
        if (i < q.size()) i++;
        waits = 0;
      end
    end
    q.delete();
    drive_addr(1'b0, mk(1'b1, 1'b0, 32'h0, 3'd0, 32'h0));
    bus.hwdata = 32'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [3:0] wen0;
    txn_t idle_t;
    idle_t = mk(1'b1, 1'b0, 32'h0, 3'd0, 32'h0);
    mem_init = 1'b1; hresetn = 1'b0; bus.bist_te = 1'b0; bus.hwdata = 32'h0;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);

    // Reset with a read request pending on the bus.
    drive_addr(1'b1, mk(1'b0, 1'b0, 32'h40, 3'd2, 32'h0));
    repeat (2) @(posedge hclk);
    #1 mem_init = 1'b0;
    @(negedge hclk);
    chk("rst hready_out", 32'(bus.hready_out), 32'd1);
    chk("rst hresp", 32'(bus.hresp), 32'd0);
    chk("rst hrdata", bus.hrdata, 32'h0);
    chk("rst cen", 32'(bus.sram_cen), 32'd1);
    chk("rst oen", 32'(bus.sram_oen), 32'd1);
    chk("rst wen", 32'(bus.sram_wen), 32'hF);
    chk("rst addr", 32'(bus.sram_addr), 32'h0);
    chk("rst wdata", bus.sram_wdata, 32'h0);
    @(posedge hclk); #1;
    drive_addr(1'b0, idle_t);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Word write, gap, read back.
    q.push_back(mk(1'b0, 1'b1, 32'h10, 3'd2, 32'hA5A5_5A5A));
    q.push_back(idle_t);
    q.push_back(mk(1'b0, 1'b0, 32'h10, 3'd2, 32'h0));
    run_seq();
    chk("w010 wen", 32'(last_wen), 32'h0);
    chk("w010 addr", 32'(last_waddr), 32'h4);
    chk("r010 addr", 32'(last_raddr), 32'h4);

    // Byte lane 3 write.
    q.push_back(mk(1'b0, 1'b1, 32'h3, 3'd0, 32'h7700_0000));
    q.push_back(idle_t);
    q.push_back(mk(1'b0, 1'b0, 32'h0, 3'd2, 32'h0));
    run_seq();
    chk("b003 wen", 32'(last_wen), 32'h7);

    // Read immediately after write to the same word.
    q.push_back(mk(1'b0, 1'b1, 32'h20, 3'd2, 32'hC0DE_F00D));
    q.push_back(mk(1'b0, 1'b0, 32'h20, 3'd2, 32'h0));
    run_seq();

    // Top word of the array.
    q.push_back(mk(1'b0, 1'b1, 32'h7FFC, 3'd2, 32'h1357_9BDF));
    q.push_back(idle_t);
    q.push_back(mk(1'b0, 1'b0, 32'h7FFC, 3'd2, 32'h0));
    run_seq();
    chk("w7ffc addr", 32'(last_waddr), 32'h1FFF);
    chk("r7ffc addr", 32'(last_raddr), 32'h1FFF);

    // BIST owns the SRAM while a read waits in its address phase.
    bus.bist_te = 1'b1;
    drive_addr(1'b1, mk(1'b0, 1'b0, 32'h10, 3'd2, 32'h0));
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      chk("bist hready_out", 32'(bus.hready_out), 32'd0);
      chk("bist cen", 32'(bus.sram_cen), 32'd1);
      @(posedge hclk); #1;
    end
    bus.bist_te = 1'b0;
    @(negedge hclk);
    chk("bist rel hready_out", 32'(bus.hready_out), 32'd1);
    chk("bist rel cen", 32'(bus.sram_cen), 32'd0);
    @(posedge hclk); #1;
    drive_addr(1'b0, idle_t);
    @(negedge hclk);
    chk("bist rdata", bus.hrdata, ref_mem[4]);
    @(posedge hclk); #1;

    // Halfword at an odd address.
    s0 = n_strobe; wen0 = last_wen;
    q.push_back(mk(1'b0, 1'b1, 32'h1, 3'd1, 32'h1234_BEEF));
    q.push_back(idle_t);
    run_seq();
    chk("h001 strobes", 32'(n_strobe - s0), ERR_EN ? 32'd0 : 32'd1);
    chk("h001 wen", 32'(last_wen), ERR_EN ? 32'(wen0) : 32'hC);
    q.push_back(mk(1'b0, 1'b0, 32'h0, 3'd2, 32'h0));
    run_seq();

    // Reset during a write data phase aborts the write.
    drive_addr(1'b1, mk(1'b0, 1'b1, 32'h30, 3'd2, 32'h0));
    @(negedge hclk);
    chk("abort acc", 32'(bus.hready_out), 32'd1);
    @(posedge hclk); #1;
    drive_addr(1'b0, idle_t);
    bus.hwdata = 32'hDEAD_BEEF;
    hresetn = 1'b0; #1;
    chk("abort cen", 32'(bus.sram_cen), 32'd1);
    chk("abort wen", 32'(bus.sram_wen), 32'hF);
    chk("abort wdata", bus.sram_wdata, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1; bus.hwdata = 32'h0;
    @(posedge hclk); #1;
    q.push_back(mk(1'b0, 1'b0, 32'h30, 3'd2, 32'h0));
    run_seq();

    // Randomized transfer streams over a small hot region plus the top words.
    for (int n = 0; n < 400; n++) begin
      int          w;
      logic [1:0]  lsb;
      logic [2:0]  sz;
      if ($urandom_range(0, 4) == 0) begin
        q.push_back(idle_t);
      end else begin
        w   = ($urandom_range(0, 3) == 0) ? 8188 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
        lsb = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        sz  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        q.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 32'(w) * 32'd4 + 32'(lsb), sz, $urandom));
      end
    end
    run_seq();

    chk("reset strobes", 32'(n_rst_strobe), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
